// File: rtl/miner_job_scheduler.sv
// Job scheduler for a memory-access engine: a FIFO of {src,dst,len} jobs feeding a
// launch / wait / complete FSM with a watchdog, a completion counter and sticky status.
module miner_job_scheduler #(
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         Clk,
    input  logic                         RESET,
    input  logic                         Enable,
    input  logic                         Abort,
    input  logic                         Push_valid,
    output logic                         Push_ready,
    input  logic [29:0]                  Push_src,
    input  logic [29:0]                  Push_dst,
    input  logic [31:0]                  Push_len,
    output logic                         Go,
    output logic [29:0]                  Source_address,
    output logic [29:0]                  Destination_address,
    output logic [31:0]                  Length,
    input  logic                         Done,
    output logic                         Busy,
    output logic [$clog2(DEPTH+1)-1:0]   Queue_level,
    output logic [CNT_WIDTH-1:0]         Jobs_done,
    output logic                         Error,
    output logic                         Irq,
    input  logic                         Irq_clear,
    output logic [2:0]                   state_dbg
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW  = $clog2(DEPTH + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam int JW  = 92;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_WAIT     = 3'd2,
        S_COMPLETE = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [JW-1:0]        mem_q [DEPTH];
    logic [JW-1:0]        mem_d [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic [29:0]          src_q, src_d;
    logic [29:0]          dst_q, dst_d;
    logic [31:0]          len_q, len_d;
    logic [WDW-1:0]       wd_q, wd_d;
    logic [CNT_WIDTH-1:0] jobs_q, jobs_d;
    logic                 err_q, err_d;
    logic                 irq_q, irq_d;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [JW-1:0]        head;
    logic                 head_zero;
    logic                 inc_jobs;
    logic                 set_err;
    logic                 set_irq;

    // Entry layout: {src[91:62], dst[61:32], len[31:0]}.
    assign full       = (level_q == LW'(DEPTH));
    assign empty      = (level_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign head_zero  = (head[31:0] == 32'd0);
    assign Push_ready = !full && !Abort;
    assign push       = Push_valid && Push_ready;
    assign pop        = (state_q == S_IDLE) && Enable && !empty && !Abort;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (Abort) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {Push_src, Push_dst, Push_len};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (!push && pop) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        wd_d     = wd_q;
        inc_jobs = 1'b0;
        set_err  = 1'b0;
        set_irq  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    src_d   = head[91:62];
                    dst_d   = head[61:32];
                    len_d   = head[31:0];
                    // A zero-length job needs no engine work and completes at once.
                    state_d = head_zero ? S_COMPLETE : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (Done) begin
                    state_d = S_COMPLETE;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                end
            end
            S_COMPLETE: begin
                inc_jobs = 1'b1;
                set_irq  = 1'b1;
                state_d  = S_IDLE;
            end
            S_FAULT: begin
                set_err = 1'b1;
                set_irq = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort discards the job in flight, including any completion it would record.
        if (Abort) begin
            state_d  = S_IDLE;
            wd_d     = '0;
            inc_jobs = 1'b0;
            set_err  = 1'b0;
            set_irq  = 1'b0;
        end
    end

    assign jobs_d = inc_jobs ? jobs_q + 1'b1 : jobs_q;
    assign err_d  = set_err | (err_q & ~Irq_clear);
    assign irq_d  = set_irq | (irq_q & ~Irq_clear);

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            wd_q     <= '0;
            jobs_q   <= '0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            wd_q     <= wd_d;
            jobs_q   <= jobs_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
        end
    end

    assign Go                  = (state_q == S_LAUNCH);
    assign Busy                = (state_q != S_IDLE);
    assign Source_address      = src_q;
    assign Destination_address = dst_q;
    assign Length              = len_q;
    assign Queue_level         = level_q;
    assign Jobs_done           = jobs_q;
    assign Error               = err_q;
    assign Irq                 = irq_q;
    assign state_dbg           = state_q;

endmodule
